fifo_rd_unpack_one2n: RTL

Read-side width down-converter for the packed-word FIFOs. It pops one wide word from a FIFO read port (empty/inc style) and emits it as narrow units on a valid/ready stream, least-significant unit first. This is the inverse of the many-to-one packing order, where the first narrow write lands in the LSBs. It sits entirely in the FIFO read clock domain and supports full throughput with no bubble between consecutive words.

---
 rtl/fifo_rd_unpack_one2n_if.sv | 22 ++
 rtl/fifo_rd_unpack_one2n.sv | 58 +++++
 2 files changed

// File: rtl/fifo_rd_unpack_one2n_if.sv
// fifo_rd_unpack_one2n_if: FIFO read port plus narrow valid/ready stream for the unpacker
interface fifo_rd_unpack_one2n_if #(
    parameter int P_DATA_I_MSB = 31,
    parameter int P_DATA_O_MSB = 7
);
    logic                  i_fifo_empty;
    logic [P_DATA_I_MSB:0] i_fifo_data;
    logic                  o_fifo_inc;
    logic                  i_flush;
    logic [P_DATA_O_MSB:0] o_data;
    logic                  o_valid;
    logic                  o_last;
    logic                  i_ready;
    modport master (
        input  i_fifo_empty, i_fifo_data, i_flush, i_ready,
        output o_fifo_inc, o_data, o_valid, o_last
    );
    modport slave (
        output i_fifo_empty, i_fifo_data, i_flush, i_ready,
        input  o_fifo_inc, o_data, o_valid, o_last
    );
endinterface

// File: rtl/fifo_rd_unpack_one2n.sv
// fifo_rd_unpack_one2n: pops wide FIFO words and streams them out LS unit first
module fifo_rd_unpack_one2n #(
    parameter int P_DATA_I_MSB = 31,
    parameter int P_DATA_O_MSB = 7
) (
    input logic                   i_clk,
    input logic                   i_rst,
    fifo_rd_unpack_one2n_if.master bus
);
    localparam int L_W_O = P_DATA_O_MSB + 1;
    localparam int L_UNITS = (P_DATA_I_MSB + 1) / L_W_O;
    localparam int L_CNT_MSB = (L_UNITS > 1 ? $clog2(L_UNITS) : 1) - 1;
    localparam int L_LAST_I = L_UNITS - 1;
    localparam logic [L_CNT_MSB:0] L_CNT_LAST = L_LAST_I[L_CNT_MSB:0];
    localparam logic [L_CNT_MSB:0] L_CNT_PEN = L_CNT_LAST - 1'b1;
    typedef enum logic {EMPTY, HOLD} state_t;
    state_t                state;
    logic [P_DATA_I_MSB:0] word;
    logic [L_CNT_MSB:0]    cnt;
    logic                  accept;
    logic                  last_acc;
    logic                  pop;
    assign accept = bus.o_valid & bus.i_ready;
    assign last_acc = accept & (cnt == L_CNT_LAST);
    assign pop = !i_rst & !bus.i_flush & !bus.i_fifo_empty & (state == EMPTY | last_acc);
    assign bus.o_fifo_inc = pop;
    // the current unit always sits in the LSBs of the held word
    assign bus.o_data = word[P_DATA_O_MSB:0];
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= EMPTY;
            word        <= '0;
            cnt         <= '0;
            bus.o_valid <= 1'b0;
            bus.o_last  <= 1'b0;
        end else if (bus.i_flush) begin
            state       <= EMPTY;
            cnt         <= '0;
            bus.o_valid <= 1'b0;
            bus.o_last  <= 1'b0;
        end else if (pop) begin
            state       <= HOLD;
            word        <= bus.i_fifo_data;
            cnt         <= '0;
            bus.o_valid <= 1'b1;
            bus.o_last  <= (L_CNT_LAST == '0);
        end else if (last_acc) begin
            state       <= EMPTY;
            cnt         <= '0;
            bus.o_valid <= 1'b0;
            bus.o_last  <= 1'b0;
        end else if (accept) begin
            word        <= word >> L_W_O;
            cnt         <= cnt + 1'b1;
            bus.o_last  <= (cnt == L_CNT_PEN);
        end
    end
endmodule
